ft_out_merge: RTL and testbench

Merges the three metadata streams leaving the flow-table stage (in-order/fast path, forward/bypass, and reorder/slow path) into one metadata stream for the downstream packet buffer and string-matcher dispatch. It has a buffering FIFO per back-pressured source, a 3-way round-robin arbiter and a registered output stage. Drop-flagged packets can optionally be filtered out. It also exports the almost-full signals the flow-table stage uses for back-pressure.

---
 rtl/ft_out_merge.sv | 167 ++++++++++++++++
 tb/tb_ft_out_merge.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_out_merge.sv
// ft_out_merge: merges the in-order (io), forward (fw) and reorder (ro)
// metadata streams into one registered output stream through per-source
// FIFOs (io, ro) and a 3-way round-robin arbiter.
// metadata_t layout: pkt_flags occupies bits [3:0]; PKT_DROP = 4'd2.
// Optional feature macro: FT_MERGE_DROP_FILTER_EN. When it is defined,
// granted PKT_DROP beats are consumed and counted instead of being output.
module ft_out_merge #(
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = 12,
  parameter int META_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [META_WIDTH-1:0] io_meta_data,
  input  logic                  io_meta_valid,
  output logic                  io_almost_full,
  input  logic [META_WIDTH-1:0] fw_meta_data,
  input  logic                  fw_meta_valid,
  output logic                  fw_meta_ready,
  input  logic [META_WIDTH-1:0] ro_meta_data,
  input  logic                  ro_meta_valid,
  output logic                  ro_meta_ready,
  output logic                  ro_almost_full,
  output logic [META_WIDTH-1:0] out_meta_data,
  output logic                  out_meta_valid,
  input  logic                  out_meta_ready,
  output logic                  ovf_err,
  output logic [31:0]           out_cnt,
  output logic [31:0]           drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
`ifdef FT_MERGE_DROP_FILTER_EN
  localparam int FLAG_W = 4;
  localparam logic [FLAG_W-1:0] PKT_DROP = 4'd2;
`endif

  logic [META_WIDTH-1:0] io_mem_q [FIFO_DEPTH];
  logic [META_WIDTH-1:0] ro_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         io_wptr_q, io_wptr_d, io_rptr_q, io_rptr_d;
  logic [AW-1:0]         ro_wptr_q, ro_wptr_d, ro_rptr_q, ro_rptr_d;
  logic [CW-1:0]         io_cnt_q, io_cnt_d, ro_cnt_q, ro_cnt_d;
  logic                  io_af_q, io_af_d, ro_af_q, ro_af_d, ovf_q, ovf_d;
  logic                  io_full, io_wr, io_pop, ro_full, ro_wr, ro_pop;
  logic [2:0]            req;
  logic                  load, gnt_vld, drop_hit;
  logic [1:0]            gnt_idx, cand, last_q, last_d;
  logic [META_WIDTH-1:0] gnt_data, odata_q, odata_d;
  logic                  ovld_q, ovld_d;
  logic [31:0]           out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;

  assign ro_full        = (ro_cnt_q == FULL_C);
  assign ro_meta_ready  = !ro_full;
  assign io_almost_full = io_af_q;
  assign ro_almost_full = ro_af_q;
  assign ovf_err        = ovf_q;
  assign out_meta_data  = odata_q;
  assign out_meta_valid = ovld_q;
  assign out_cnt        = out_cnt_q;
  assign drop_cnt       = drop_cnt_q;

  // Round-robin grant starting after last_grant; only when the output can load.
  always_comb begin
    req     = {ro_cnt_q != '0, fw_meta_valid, io_cnt_q != '0};
    load    = !ovld_q || out_meta_ready;
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last_q) + k) % 3);
      if (load && !gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    io_pop        = gnt_vld && (gnt_idx == 2'd0);
    fw_meta_ready = gnt_vld && (gnt_idx == 2'd1);
    ro_pop        = gnt_vld && (gnt_idx == 2'd2);
    case (gnt_idx)
      2'd0:    gnt_data = io_mem_q[io_rptr_q];
      2'd1:    gnt_data = fw_meta_data;
      default: gnt_data = ro_mem_q[ro_rptr_q];
    endcase
  end

  // FIFO pointer/count bookkeeping; fullness is judged on the pre-pop count.
  always_comb begin
    io_full   = (io_cnt_q == FULL_C);
    io_wr     = io_meta_valid && !io_full;
    ovf_d     = ovf_q || (io_meta_valid && io_full);
    io_wptr_d = io_wr  ? io_wptr_q + AW'(1) : io_wptr_q;
    io_rptr_d = io_pop ? io_rptr_q + AW'(1) : io_rptr_q;
    io_cnt_d  = io_cnt_q;
    if (io_wr && !io_pop)      io_cnt_d = io_cnt_q + CW'(1);
    else if (!io_wr && io_pop) io_cnt_d = io_cnt_q - CW'(1);
    io_af_d   = (io_cnt_d >= AF_C);

    ro_wr     = ro_meta_valid && ro_meta_ready;
    ro_wptr_d = ro_wr  ? ro_wptr_q + AW'(1) : ro_wptr_q;
    ro_rptr_d = ro_pop ? ro_rptr_q + AW'(1) : ro_rptr_q;
    ro_cnt_d  = ro_cnt_q;
    if (ro_wr && !ro_pop)      ro_cnt_d = ro_cnt_q + CW'(1);
    else if (!ro_wr && ro_pop) ro_cnt_d = ro_cnt_q - CW'(1);
    ro_af_d   = (ro_cnt_d >= AF_C);
  end

  // Output register load, optional drop filtering, grant history and counters.
  always_comb begin
    drop_hit = 1'b0;
`ifdef FT_MERGE_DROP_FILTER_EN
    drop_hit = gnt_vld && (gnt_data[FLAG_W-1:0] == PKT_DROP);
`endif
    ovld_d  = ovld_q;
    odata_d = odata_q;
    if (load) begin
      ovld_d = gnt_vld && !drop_hit;
      if (gnt_vld && !drop_hit) odata_d = gnt_data;
    end
    last_d     = gnt_vld ? gnt_idx : last_q;
    out_cnt_d  = out_cnt_q + ((ovld_q && out_meta_ready) ? 32'd1 : 32'd0);
    drop_cnt_d = drop_cnt_q + (drop_hit ? 32'd1 : 32'd0);
  end

  // Control and output state; reset discards all buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_wptr_q  <= '0;
      io_rptr_q  <= '0;
      io_cnt_q   <= '0;
      ro_wptr_q  <= '0;
      ro_rptr_q  <= '0;
      ro_cnt_q   <= '0;
      io_af_q    <= 1'b0;
      ro_af_q    <= 1'b0;
      ovf_q      <= 1'b0;
      ovld_q     <= 1'b0;
      odata_q    <= '0;
      last_q     <= 2'd2;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      io_wptr_q  <= io_wptr_d;
      io_rptr_q  <= io_rptr_d;
      io_cnt_q   <= io_cnt_d;
      ro_wptr_q  <= ro_wptr_d;
      ro_rptr_q  <= ro_rptr_d;
      ro_cnt_q   <= ro_cnt_d;
      io_af_q    <= io_af_d;
      ro_af_q    <= ro_af_d;
      ovf_q      <= ovf_d;
      ovld_q     <= ovld_d;
      odata_q    <= odata_d;
      last_q     <= last_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage; entries are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (io_wr) io_mem_q[io_wptr_q] <= io_meta_data;
    if (ro_wr) ro_mem_q[ro_wptr_q] <= ro_meta_data;
  end

endmodule

// File: tb/tb_ft_out_merge.sv
// Testbench for ft_out_merge: per-source expected queues filled on accepted
// input beats, drained by an independent output monitor.
module tb_ft_out_merge;
  localparam int MW = 32;
  localparam logic [3:0] F_CHECK = 4'd1;
  localparam logic [3:0] F_DROP  = 4'd2;
  localparam logic [3:0] F_FWD   = 4'd3;
`ifdef FT_MERGE_DROP_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [MW-1:0] io_meta_data = '0, fw_meta_data = '0, ro_meta_data = '0;
  logic          io_meta_valid = 1'b0, fw_meta_valid = 1'b0, ro_meta_valid = 1'b0;
  logic          io_almost_full, fw_meta_ready, ro_meta_ready, ro_almost_full;
  logic [MW-1:0] out_meta_data;
  logic          out_meta_valid, ovf_err;
  logic          out_meta_ready = 1'b0;
  logic [31:0]   out_cnt, drop_cnt;

  always #5 clk = ~clk;

  ft_out_merge #(.FIFO_DEPTH(16), .AF_LEVEL(12), .META_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_meta_data(io_meta_data), .io_meta_valid(io_meta_valid), .io_almost_full(io_almost_full),
    .fw_meta_data(fw_meta_data), .fw_meta_valid(fw_meta_valid), .fw_meta_ready(fw_meta_ready),
    .ro_meta_data(ro_meta_data), .ro_meta_valid(ro_meta_valid), .ro_meta_ready(ro_meta_ready),
    .ro_almost_full(ro_almost_full),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .ovf_err(ovf_err), .out_cnt(out_cnt), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] q_io[$], q_fw[$], q_ro[$];
  int exp_drop = 0, xfer_cnt = 0, out_io_n = 0, seq = 0;
  bit log_en = 1'b0;
  int src_log[$];
  int fw_hs[$];
  logic [MW-1:0] t2 [3];
  logic [MW-1:0] mon_e;
  bit mon_ok;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input int src, input int sq, input logic [3:0] fl);
    return {src[1:0], sq[25:0], fl};
  endfunction

  function automatic logic [3:0] rflag();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 2) return F_DROP;
    if (r < 6) return F_CHECK;
    return F_FWD;
  endfunction

  // Record an accepted input beat: either expected on the output or expected dropped.
  task automatic expect_beat(input logic [MW-1:0] d);
    if (FILT && d[3:0] == F_DROP) exp_drop++;
    else begin
      case (d[31:30])
        2'd0:    q_io.push_back(d);
        2'd1:    q_fw.push_back(d);
        default: q_ro.push_back(d);
      endcase
    end
  endtask

  // One cycle: inputs already driven; sample handshakes at negedge, return at posedge+1.
  task automatic cyc(input bit io_acc);
    @(negedge clk);
    if (io_meta_valid && io_acc) expect_beat(io_meta_data);
    if (fw_meta_valid && fw_meta_ready) expect_beat(fw_meta_data);
    if (ro_meta_valid && ro_meta_ready) expect_beat(ro_meta_data);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    io_meta_valid = 1'b0; fw_meta_valid = 1'b0; ro_meta_valid = 1'b0;
    out_meta_ready = 1'b1;
    while ((q_io.size() + q_fw.size() + q_ro.size() != 0 || out_meta_valid) && n < 300) begin
      cyc(1'b1);
      n++;
    end
    check({name, "_drain_done"}, 64'(n < 300), 64'(1));
    for (int i = 0; i < 40; i++) cyc(1'b1);
  endtask

  // Output monitor: every transfer must match the head of its source's queue.
  always @(negedge clk) begin
    if (rst_n && out_meta_valid && out_meta_ready) begin
      xfer_cnt++;
      if (log_en) src_log.push_back(int'(out_meta_data[31:30]));
      mon_ok = 1'b1;
      mon_e  = '0;
      case (out_meta_data[31:30])
        2'd0: begin
          out_io_n++;
          if (q_io.size() > 0) mon_e = q_io.pop_front(); else mon_ok = 1'b0;
        end
        2'd1: if (q_fw.size() > 0) mon_e = q_fw.pop_front(); else mon_ok = 1'b0;
        2'd2: if (q_ro.size() > 0) mon_e = q_ro.pop_front(); else mon_ok = 1'b0;
        default: mon_ok = 1'b0;
      endcase
      if (mon_ok) check("out_beat", 64'(out_meta_data), 64'(mon_e));
      else begin
        checks++;
        errors++;
        $display("FAIL out_unexpected actual=%0h required=none", out_meta_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_hs, io_before;
    bit need_new, fw_acc, ro_acc;
    logic [3:0] fl [3];

    // ---- reset values
    #12;
    check("rst_out_valid", 64'(out_meta_valid), 64'(0));
    check("rst_out_data",  64'(out_meta_data), 64'(0));
    check("rst_ovf",       64'(ovf_err), 64'(0));
    check("rst_out_cnt",   64'(out_cnt), 64'(0));
    check("rst_drop_cnt",  64'(drop_cnt), 64'(0));
    check("rst_io_af",     64'(io_almost_full), 64'(0));
    check("rst_ro_af",     64'(ro_almost_full), 64'(0));
    check("rst_ro_ready",  64'(ro_meta_ready), 64'(1));
    check("rst_fw_ready",  64'(fw_meta_ready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- three back-to-back forward beats, one cycle latency each
    out_meta_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        seq++;
        fw_meta_valid = 1'b1;
        fw_meta_data  = mk(1, seq, F_CHECK);
        t2[i] = fw_meta_data;
      end else fw_meta_valid = 1'b0;
      @(negedge clk);
      if (i < 3) check("t2_fw_ready", 64'(fw_meta_ready), 64'(1));
      if (i > 0) begin
        check("t2_out_valid", 64'(out_meta_valid), 64'(1));
        check("t2_out_data",  64'(out_meta_data), 64'(t2[i-1]));
      end
      if (fw_meta_valid && fw_meta_ready) expect_beat(fw_meta_data);
      @(posedge clk); #1;
    end
    cyc(1'b1);
    check("t2_out_cnt", 64'(out_cnt), 64'(3));
    check("t2_out_idle", 64'(out_meta_valid), 64'(0));

    // ---- in-order FIFO fill, almost-full and overflow
    out_meta_ready = 1'b0;
    seq++;
    fw_meta_valid = 1'b1;
    fw_meta_data  = mk(1, seq, F_CHECK);
    cyc(1'b1);
    fw_meta_valid = 1'b0;
    io_before = out_io_n;
    for (int i = 1; i <= 17; i++) begin
      seq++;
      io_meta_valid = 1'b1;
      io_meta_data  = mk(0, seq, F_CHECK);
      @(negedge clk);
      check("t3_io_af", 64'(io_almost_full), 64'((i - 1) >= 12));
      check("t3_ovf_clear", 64'(ovf_err), 64'(0));
      if (i <= 16) expect_beat(io_meta_data);
      @(posedge clk); #1;
    end
    io_meta_valid = 1'b0;
    @(negedge clk);
    check("t3_ovf_set", 64'(ovf_err), 64'(1));
    check("t3_io_af_full", 64'(io_almost_full), 64'(1));
    @(posedge clk); #1;
    drain("t3");
    check("t3_io_beats_out", 64'(out_io_n - io_before), 64'(16));
    check("t3_ovf_sticky", 64'(ovf_err), 64'(1));

    // ---- three-way contention: strict io -> fw -> ro rotation
    out_meta_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seq++;
      io_meta_valid = 1'b1; io_meta_data = mk(0, seq, F_CHECK);
      ro_meta_valid = 1'b1; ro_meta_data = mk(2, seq, F_FWD);
      cyc(1'b1);
    end
    io_meta_valid = 1'b0; ro_meta_valid = 1'b0;
    src_log.delete(); fw_hs.delete();
    out_meta_ready = 1'b1;
    seq++;
    fw_meta_valid = 1'b1; fw_meta_data = mk(1, seq, F_CHECK);
    log_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      fw_acc = fw_meta_ready;
      if (fw_acc) begin
        fw_hs.push_back(i);
        expect_beat(fw_meta_data);
      end
      @(posedge clk); #1;
      if (fw_acc) begin seq++; fw_meta_data = mk(1, seq, F_CHECK); end
    end
    log_en = 1'b0;
    fw_meta_valid = 1'b0;
    check("t4_log_len", 64'(src_log.size()), 64'(12));
    for (int k = 1; k < src_log.size(); k++)
      check("t4_rr_order", 64'(src_log[k]), 64'((src_log[k-1] + 1) % 3));
    check("t4_fw_count", 64'(fw_hs.size()), 64'(4));
    for (int k = 1; k < fw_hs.size(); k++)
      check("t4_fw_gap", 64'(fw_hs[k] - fw_hs[k-1]), 64'(3));
    drain("t4");

    // ---- reorder FIFO full back-pressure
    out_meta_ready = 1'b0;
    n_hs = 0;
    seq++;
    ro_meta_valid = 1'b1; ro_meta_data = mk(2, seq, F_CHECK);
    need_new = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (need_new) begin seq++; ro_meta_data = mk(2, seq, F_CHECK); need_new = 1'b0; end
      @(negedge clk);
      if (ro_meta_ready) begin n_hs++; expect_beat(ro_meta_data); need_new = 1'b1; end
      @(posedge clk); #1;
    end
    ro_meta_valid = 1'b0;
    @(negedge clk);
    check("t5_ro_accepted", 64'(n_hs), 64'(17));
    check("t5_ro_ready_full", 64'(ro_meta_ready), 64'(0));
    check("t5_ro_af", 64'(ro_almost_full), 64'(1));
    @(posedge clk); #1;
    out_meta_ready = 1'b1;
    cyc(1'b1);
    out_meta_ready = 1'b0;
    @(negedge clk);
    check("t5_ro_ready_after_pop", 64'(ro_meta_ready), 64'(1));
    @(posedge clk); #1;
    drain("t5");

    // ---- asynchronous reset with entries buffered
    out_meta_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seq++;
      io_meta_valid = 1'b1; io_meta_data = mk(0, seq, F_CHECK);
      cyc(1'b1);
    end
    io_meta_valid = 1'b0;
    cyc(1'b1);
    check("t6_pre_valid", 64'(out_meta_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_meta_valid), 64'(0));
    check("t6_rst_data",  64'(out_meta_data), 64'(0));
    check("t6_rst_ovf",   64'(ovf_err), 64'(0));
    check("t6_rst_out_cnt", 64'(out_cnt), 64'(0));
    check("t6_rst_drop_cnt", 64'(drop_cnt), 64'(0));
    check("t6_rst_io_af", 64'(io_almost_full), 64'(0));
    check("t6_rst_ro_ready", 64'(ro_meta_ready), 64'(1));
    q_io.delete(); q_fw.delete(); q_ro.delete();
    exp_drop = 0;
    xfer_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_meta_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b1);
    check("t6_no_stale", 64'(xfer_cnt), 64'(0));
    check("t6_idle", 64'(out_meta_valid), 64'(0));

    // ---- drop-flagged beats
    fl[0] = F_CHECK; fl[1] = F_DROP; fl[2] = F_FWD;
    for (int i = 0; i < 3; i++) begin
      seq++;
      io_meta_valid = 1'b1; io_meta_data = mk(0, seq, fl[i]);
      cyc(1'b1);
    end
    io_meta_valid = 1'b0;
    drain("t7");
    check("t7_out_cnt", 64'(out_cnt), 64'(FILT ? 2 : 3));
    check("t7_drop_cnt", 64'(drop_cnt), 64'(FILT ? 1 : 0));
    check("t7_xfers", 64'(xfer_cnt), 64'(FILT ? 2 : 3));

    // ---- randomized traffic with a source honouring almost-full
    fw_acc = 1'b0; ro_acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      out_meta_ready = ($urandom_range(0, 9) < 7);
      io_meta_valid  = !io_almost_full && ($urandom_range(0, 1) == 1);
      if (io_meta_valid) begin seq++; io_meta_data = mk(0, seq, rflag()); end
      if (fw_acc || !fw_meta_valid) begin
        fw_meta_valid = ($urandom_range(0, 2) == 0);
        if (fw_meta_valid) begin seq++; fw_meta_data = mk(1, seq, rflag()); end
      end
      if (ro_acc || !ro_meta_valid) begin
        ro_meta_valid = ($urandom_range(0, 2) != 0);
        if (ro_meta_valid) begin seq++; ro_meta_data = mk(2, seq, rflag()); end
      end
      @(negedge clk);
      if (io_meta_valid) expect_beat(io_meta_data);
      fw_acc = fw_meta_valid && fw_meta_ready;
      if (fw_acc) expect_beat(fw_meta_data);
      ro_acc = ro_meta_valid && ro_meta_ready;
      if (ro_acc) expect_beat(ro_meta_data);
      @(posedge clk); #1;
    end
    drain("t8");
    check("t8_ovf", 64'(ovf_err), 64'(0));
    check("t8_out_cnt", 64'(out_cnt), 64'(xfer_cnt));
    check("t8_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check("t8_queues_empty", 64'(q_io.size() + q_fw.size() + q_ro.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
